// File: rtl/core_pkg.sv
//------------------------------------------------------------------------------
// Module   : core_pkg
// Purpose  : Shared loader state encoding and default sizing constants.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;

  localparam int unsigned c_default_mem_words      = 256;
  localparam int unsigned c_default_timeout_cycles = 10000000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_event_timer.sv
//------------------------------------------------------------------------------
// Module   : byte_event_timer
// Purpose  : Rising-edge byte event detector plus saturating inter-byte timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_event_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx_ready,
  input  logic i_run,
  input  logic i_clr,
  output logic o_byte_evt,
  output logic o_timeout
);

  localparam int unsigned          c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(TIMEOUT_CYCLES);

  logic               r_rx_prev;
  logic               r_seen_low;
  logic [c_cnt_w-1:0] r_cnt;

  // A level that is already high when reset releases must drop before it counts.
  assign o_byte_evt = i_rx_ready & ~r_rx_prev & r_seen_low;
  assign o_timeout  = i_run & (r_cnt == c_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_prev  <= 1'b0;
      r_seen_low <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rx_prev <= i_rx_ready;
      if (!i_rx_ready) begin
        r_seen_low <= 1'b1;
      end
      if (!i_run || i_clr || o_byte_evt) begin
        r_cnt <= '0;
      end else if (r_cnt != c_limit) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// Module   : program_loader
// Purpose  : Receives a length-prefixed little-endian byte stream and writes
//            assembled 32-bit words into instruction memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module program_loader
  import core_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = c_default_mem_words,
  parameter int unsigned TIMEOUT_CYCLES = c_default_timeout_cycles
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [7:0]                   RX_DATA,
  input  logic                         RX_READY,
  input  logic                         START,
  output logic                         MEM_WE,
  output logic [$clog2(MEM_WORDS)-1:0] MEM_ADDR,
  output logic [31:0]                  MEM_WDATA,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERROR,
  output logic [$clog2(MEM_WORDS):0]   WORD_COUNT
);

  localparam int unsigned        c_aw        = $clog2(MEM_WORDS);
  localparam int unsigned        c_cw        = c_aw + 1;
  localparam logic [31:0]        c_max_bytes = 32'(4 * MEM_WORDS);
  localparam logic [c_cw-1:0]    c_max_words = c_cw'(MEM_WORDS);

  loader_state_t   r_state;
  loader_state_t   w_next;

  logic            w_evt;
  logic            w_timeout;
  logic            w_run;
  logic            w_start;

  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_len;
  logic [23:0]     r_word;
  logic [c_cw-1:0] r_len_words;
  logic [c_cw-1:0] r_word_count;
  logic            r_we;
  logic [c_aw-1:0] r_addr;
  logic [31:0]     r_wdata;

  logic [31:0]     w_len_next;
  logic [31:0]     w_word_next;
  logic            w_len_bad;
  logic [c_cw-1:0] w_count_eff;
  logic            w_last;
  logic            w_fourth;

  assign w_run   = (r_state == ST_LEN) || (r_state == ST_LOAD);
  assign w_start = START && !w_run;

  byte_event_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_byte_event_timer (
    .clk        (CLK),
    .rst        (RST),
    .i_rx_ready (RX_READY),
    .i_run      (w_run),
    .i_clr      (w_start),
    .o_byte_evt (w_evt),
    .o_timeout  (w_timeout)
  );

  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  assign w_len_next  = {RX_DATA, r_len};
  assign w_word_next = {RX_DATA, r_word};
  assign w_fourth    = w_evt && (r_byte_cnt == 2'd3);
  assign w_len_bad   = (w_len_next == 32'd0) || (w_len_next[1:0] != 2'b00) ||
                       (w_len_next > c_max_bytes);
  // Counts a write still in flight so the final-word test never lags behind.
  assign w_count_eff = r_word_count + c_cw'(r_we);
  assign w_last      = ((w_count_eff + c_cw'(1)) == r_len_words);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (START) begin
          w_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_timeout) begin
          w_next = ST_ERR;
        end else if (w_fourth) begin
          w_next = w_len_bad ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_timeout) begin
          w_next = ST_ERR;
        end else if (w_fourth && w_last) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY  = 1'b0;
    DONE  = 1'b0;
    ERROR = 1'b0;
    case (r_state)
      ST_LEN, ST_LOAD: BUSY  = 1'b1;
      ST_DONE:         DONE  = 1'b1;
      ST_ERR:          ERROR = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_byte_cnt   <= 2'd0;
      r_len        <= '0;
      r_word       <= '0;
      r_len_words  <= '0;
      r_word_count <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      if (r_we && (r_word_count != c_max_words)) begin
        r_word_count <= r_word_count + c_cw'(1);
      end
      if (w_start) begin
        r_byte_cnt   <= 2'd0;
        r_len        <= '0;
        r_word       <= '0;
        r_len_words  <= '0;
        r_word_count <= '0;
      end else if (w_evt && !w_timeout) begin
        if (r_state == ST_LEN) begin
          r_len      <= w_len_next[31:8];
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_len_words <= w_len_next[c_aw+2:2];
          end
        end else if (r_state == ST_LOAD) begin
          r_word     <= w_word_next[31:8];
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_we    <= 1'b1;
            r_addr  <= w_count_eff[c_aw-1:0];
            r_wdata <= w_word_next;
          end
        end
      end
    end
  end

  assign MEM_WE     = r_we;
  assign MEM_ADDR   = r_addr;
  assign MEM_WDATA  = r_wdata;
  assign WORD_COUNT = r_word_count;

endmodule

`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_WORDS, 256, depth of instruction memory in 32-bit words (1024 bytes).
REQ-002 Parameter TIMEOUT_CYCLES, 10000000, idle CLK cycles allowed between bytes before abort.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 RX_DATA  input  8  byte from UART receiver; valid when RX_READY rises.
REQ-006 RX_READY  input  1  receiver ready level; each 0->1 transition marks one new byte.
REQ-007 START  input  1  one-cycle arm request.
REQ-008 MEM_WE  output  1  one-cycle write strobe to instruction memory.
REQ-009 MEM_ADDR  output  $clog2(MEM_WORDS)  word address of the write.
REQ-010 MEM_WDATA  output  32  assembled instruction word.
REQ-011 BUSY  output  1  high in LEN and LOAD.
REQ-012 DONE  output  1  high in DONE state.
REQ-013 ERROR  output  1  high in ERR state.
REQ-014 WORD_COUNT  output  $clog2(MEM_WORDS)+1  words written in the current load.

Function
REQ-015 The block SHALL register RX_READY once and treat (RX_READY & ~prev) as a byte event; a level held high SHALL yield exactly one event.
REQ-016 States: IDLE, LEN, LOAD, DONE, ERR.
REQ-017 IDLE: byte events ignored; START -> LEN, clearing byte counter, WORD_COUNT, length register and timeout counter.
REQ-018 LEN: 4 byte events form 32-bit byte length, little-endian (first byte -> bits 7:0).
REQ-019 After 4th length byte: length 0, not multiple of 4, or > 4*MEM_WORDS -> ERR; otherwise -> LOAD.
REQ-020 LOAD: byte events assemble a word little-endian; byte k of word -> bits 8k+7:8k.
REQ-021 On the 4th byte of a word, the next cycle SHALL assert MEM_WE for one cycle with MEM_WDATA = word, MEM_ADDR = WORD_COUNT (pre-increment), then WORD_COUNT increments.
REQ-022 Latency from 4th byte event to MEM_WE = 1 cycle; MEM_ADDR/MEM_WDATA stable only while MEM_WE is high and 0 otherwise.
REQ-023 When the write of word number length/4 completes, state -> DONE in the same cycle MEM_WE is high.
REQ-024 Timeout counter clears on each byte event and on entering LEN; reaching TIMEOUT_CYCLES in LEN or LOAD -> ERR; no partial word written.
REQ-025 START while BUSY SHALL be ignored; START in DONE or ERR restarts as from IDLE.
REQ-026 A byte event in the same cycle as MEM_WE SHALL be captured as byte 0 of the next word.
REQ-027 Byte events in DONE/ERR SHALL be ignored; WORD_COUNT holds its final value until next START.
REQ-028 Counters SHALL not wrap: WORD_COUNT max = MEM_WORDS; timeout counter saturates.

Reset
REQ-029 RST high SHALL immediately force IDLE, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, DONE=0, ERROR=0, WORD_COUNT=0, prev RX_READY=0.
REQ-030 RST mid-load SHALL abort without a further MEM_WE; partial word discarded.
REQ-031 First byte event after RST release requires RX_READY low-to-high observed after release.

Structure
REQ-032 State enum type and default MEM_WORDS/TIMEOUT_CYCLES constants SHALL live in shared package core_pkg.
REQ-033 Edge detect + timeout counter SHALL be one sub-module, byte_event_timer; the FSM and word assembly stay in program_loader.

Verification
REQ-034 START, bytes 08 00 00 00, 13 00 00 00, 0C 00 00 00 -> MEM_WE at addr 0 data 0x00000013, addr 1 data 0x0000000C, DONE=1, WORD_COUNT=2.
REQ-035 START, length bytes 06 00 00 00 -> ERROR=1, no MEM_WE.
REQ-036 START, length 0x404 -> ERROR=1; length 0x400 with 1024 bytes -> 256 writes, last addr 255, DONE=1.
REQ-037 START, length 8, send 5 bytes then silence TIMEOUT_CYCLES (set 1000) -> ERROR=1, exactly one MEM_WE.
REQ-038 RST asserted after 6 payload bytes -> all outputs 0 same cycle; fresh START + valid 4-byte load succeeds at addr 0.
REQ-039 RX_READY held high 50 cycles, START pulsed during LOAD -> one byte captured, START ignored, load completes unchanged.
